// File: rtl/spi_fifo_port_if.sv
// spi_fifo_port_if: peripheral bus seen by the SPI FIFO port
interface spi_fifo_port_if;
    logic        enable;
    logic        write_enable;
    logic [1:0]  address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    modport master(output enable, write_enable, address, data_in, input data_out);
    modport slave(input enable, write_enable, address, data_in, output data_out);
endinterface

// File: rtl/spi_fifo_port.sv
// spi_fifo_port: memory-mapped mode-0 SPI master with TX/RX FIFOs and chip selects
module spi_fifo_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CS = 2
) (
    input  logic              raw_clk,
    input  logic              reset,
    spi_fifo_port_if.slave    bus,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_t;
    state_t state, state_n;
    logic [15:0] tx_mem [FIFO_DEPTH];
    logic [15:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic en_q, ctrl_go, ctrl_w16, w16_l, tx_ovf, rx_ovf;
    logic [3:0] ctrl_div, div_l, tick, bit_cnt;
    logic [1:0] ctrl_cs, cs_l;
    logic [15:0] sh, rx_sh, rx_word, rd_data;
    logic acc, wr, rd, tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop, tick_end, last, start;
    logic [NUM_CS-1:0] cs_mask;

    always_comb begin
        acc = bus.enable && !en_q;
        wr = acc && bus.write_enable;
        rd = acc && !bus.write_enable;
        tx_full = tx_cnt == CW'(FIFO_DEPTH);
        tx_empty = tx_cnt == '0;
        rx_full = rx_cnt == CW'(FIFO_DEPTH);
        rx_empty = rx_cnt == '0;
        tx_push = wr && bus.address == 2'd0 && !tx_full;
        tx_pop = state == LOAD;
        rx_push = state == DONE && !rx_full;
        rx_pop = rd && bus.address == 2'd0 && !rx_empty;
        tick_end = tick == div_l;
        last = bit_cnt == (w16_l ? 4'd15 : 4'd7);
        rx_word = w16_l ? rx_sh : {8'd0, rx_sh[7:0]};
        state_n = state;
        case (state)
            IDLE:    state_n = ctrl_go && !tx_empty ? LOAD : IDLE;
            LOAD:    state_n = LOW;
            LOW:     state_n = tick_end ? HIGH : LOW;
            HIGH:    state_n = !tick_end ? HIGH : last ? DONE : LOW;
            default: state_n = IDLE;
        endcase
        start = state == IDLE && state_n == LOAD;
        // the select index comes from CTRL only at word start, then from the latched copy
        cs_mask = '1;
        for (int i = 0; i < NUM_CS; i++) cs_mask[i] = (start ? ctrl_cs : cs_l) != 2'(i);
        rd_data = bus.address == 2'd0 ? (rx_empty ? 16'd0 : rx_mem[rx_rp])
                : bus.address == 2'd1 ? {6'd0, ctrl_cs, ctrl_div, 1'b0, ctrl_w16, 1'b0, ctrl_go}
                : bus.address == 2'd2 ? {9'd0, rx_ovf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty, state != IDLE}
                : {8'(rx_cnt), 8'(tx_cnt)};
    end

    always_ff @(posedge raw_clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.data_in;
        if (rx_push) rx_mem[rx_wp] <= rx_word;
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state <= IDLE;
            en_q <= 1'b0;
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
            ctrl_go <= 1'b0;
            ctrl_w16 <= 1'b0;
            ctrl_div <= '0;
            ctrl_cs <= '0;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            w16_l <= 1'b0;
            div_l <= '0;
            cs_l <= '0;
            tick <= '0;
            bit_cnt <= '0;
            sh <= '0;
            rx_sh <= '0;
            bus.data_out <= '0;
            spi_clk <= 1'b0;
            spi_cs <= '1;
        end else begin
            state <= state_n;
            en_q <= bus.enable;
            tx_wp <= tx_wp + AW'(tx_push);
            tx_rp <= tx_rp + AW'(tx_pop);
            rx_wp <= rx_wp + AW'(rx_push);
            rx_rp <= rx_rp + AW'(rx_pop);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            tx_ovf <= (wr && bus.address == 2'd0 && tx_full) || (tx_ovf && !(wr && bus.address == 2'd2 && bus.data_in[5]));
            rx_ovf <= (state == DONE && rx_full) || (rx_ovf && !(wr && bus.address == 2'd2 && bus.data_in[6]));
            if (wr && bus.address == 2'd1) begin
                ctrl_go <= bus.data_in[0];
                ctrl_w16 <= bus.data_in[2];
                ctrl_div <= bus.data_in[7:4];
                ctrl_cs <= bus.data_in[9:8];
            end
            if (rd) bus.data_out <= rd_data;
            // 8-bit words are left-aligned so the MSB always leaves from sh[15]
            if (start) begin
                sh <= ctrl_w16 ? tx_mem[tx_rp] : {tx_mem[tx_rp][7:0], 8'd0};
                w16_l <= ctrl_w16;
                div_l <= ctrl_div;
                cs_l <= ctrl_cs;
                bit_cnt <= '0;
            end
            tick <= (state == LOW || state == HIGH) && !tick_end ? tick + 4'd1 : 4'd0;
            if (state == LOW && tick_end) rx_sh <= {rx_sh[14:0], spi_miso};
            if (state == HIGH && tick_end) begin
                sh <= {sh[14:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end
            spi_clk <= state_n == HIGH;
            spi_cs <= state_n == IDLE ? '1 : cs_mask;
        end
    end

    assign spi_mosi = sh[15];
endmodule

// File: tb/tb_spi_fifo_port.sv
// tb_spi_fifo_port: directed checks of the SPI FIFO port in MOSI->MISO loopback
module tb_spi_fifo_port;
    logic raw_clk = 1'b0;
    logic reset = 1'b1;
    logic spi_clk, spi_mosi, spi_miso;
    logic [1:0] spi_cs;
    int n_cmp = 0, n_err = 0;
    int sclk_rises = 0, sclk_high = 0, cs0_low = 0, cs_falls = 0;
    logic prev_clk = 1'b0;
    logic [1:0] prev_cs = 2'b11;

    spi_fifo_port_if bus();

    spi_fifo_port #(.FIFO_DEPTH(4), .NUM_CS(2)) dut (
        .raw_clk(raw_clk),
        .reset(reset),
        .bus(bus),
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_cs(spi_cs)
    );

    assign spi_miso = spi_mosi;
    always #5 raw_clk = ~raw_clk;

    always @(posedge raw_clk) begin
        #1;
        if (spi_clk && !prev_clk) sclk_rises++;
        if (spi_clk) sclk_high++;
        if (!spi_cs[0]) cs0_low++;
        if ((prev_cs & ~spi_cs) != 2'b00) cs_falls++;
        prev_clk = spi_clk;
        prev_cs = spi_cs;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge raw_clk);
        bus.enable = 1'b1;
        bus.write_enable = 1'b1;
        bus.address = a;
        bus.data_in = d;
        @(negedge raw_clk);
        bus.enable = 1'b0;
        bus.write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge raw_clk);
        bus.enable = 1'b1;
        bus.write_enable = 1'b0;
        bus.address = a;
        @(negedge raw_clk);
        bus.enable = 1'b0;
        d = bus.data_out;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // waits until TX has drained and the engine is idle
    task automatic wait_idle(input string tag);
        logic [15:0] s;
        int n;
        n = 0;
        repeat (3) @(negedge raw_clk);
        do begin
            bus_read(2'd2, s);
            n++;
        end while (!(s[0] == 1'b0 && s[1] == 1'b1) && n < 400);
        check(tag, {14'd0, s[1:0]}, 16'h0002);
    endtask

    task automatic do_reset();
        @(negedge raw_clk);
        reset = 1'b1;
        repeat (2) @(negedge raw_clk);
        reset = 1'b0;
    endtask

    initial begin
        int b_r, b_h, b_l, b_f, n;
        logic [15:0] d;
        bus.enable = 1'b0;
        bus.write_enable = 1'b0;
        bus.address = 2'd0;
        bus.data_in = 16'd0;
        repeat (3) @(negedge raw_clk);
        check("rst_cs", {14'd0, spi_cs}, 16'h0003);
        check("rst_sclk", {15'd0, spi_clk}, 16'h0000);
        check("rst_mosi", {15'd0, spi_mosi}, 16'h0000);
        check("rst_dout", bus.data_out, 16'h0000);
        reset = 1'b0;
        read_check("rst_status", 2'd2, 16'h000A);
        read_check("rst_level", 2'd3, 16'h0000);

        // T1: 8-bit word, div=0
        bus_write(2'd1, 16'h0001);
        b_r = sclk_rises; b_h = sclk_high; b_l = cs0_low;
        bus_write(2'd0, 16'h00A5);
        wait_idle("t1_idle");
        check("t1_rises", 16'(sclk_rises - b_r), 16'd8);
        check("t1_high", 16'(sclk_high - b_h), 16'd8);
        check("t1_cs_low", 16'(cs0_low - b_l), 16'd18);
        read_check("t1_level", 2'd3, 16'h0100);
        read_check("t1_rx", 2'd0, 16'h00A5);
        read_check("t1_status", 2'd2, 16'h000A);

        // T2: 16-bit word, div=3
        bus_write(2'd1, 16'h0035);
        read_check("t2_ctrl", 2'd1, 16'h0035);
        b_r = sclk_rises; b_h = sclk_high; b_l = cs0_low;
        bus_write(2'd0, 16'h1234);
        wait_idle("t2_idle");
        check("t2_rises", 16'(sclk_rises - b_r), 16'd16);
        check("t2_high", 16'(sclk_high - b_h), 16'd64);
        check("t2_busy_len", 16'(cs0_low - b_l), 16'd130);
        read_check("t2_rx", 2'd0, 16'h1234);

        // T3: TX overflow with go=0, then clear tx_ovf
        bus_write(2'd1, 16'h0000);
        for (int i = 0; i < 5; i++) bus_write(2'd0, 16'(8'h11 + i));
        read_check("t3_status", 2'd2, 16'h002C);
        read_check("t3_level", 2'd3, 16'h0004);
        bus_write(2'd2, 16'h0020);
        read_check("t3_clr", 2'd2, 16'h000C);

        // T4: RX fills, then overflows without corrupting stored words
        do_reset();
        for (int i = 0; i < 6; i++) bus_write(2'd0, 16'(8'hA1 + i));
        bus_write(2'd2, 16'h0020);
        bus_write(2'd1, 16'h0001);
        wait_idle("t4_idle");
        read_check("t4_full", 2'd2, 16'h0012);
        read_check("t4_level", 2'd3, 16'h0400);
        bus_write(2'd0, 16'h00B7);
        wait_idle("t4_idle2");
        read_check("t4_ovf", 2'd2, 16'h0052);
        for (int i = 0; i < 4; i++) read_check("t4_rx", 2'd0, 16'(8'hA1 + i));
        read_check("t4_empty_rd", 2'd0, 16'h0000);
        read_check("t4_status", 2'd2, 16'h004A);
        bus_write(2'd2, 16'h0040);
        read_check("t4_clr", 2'd2, 16'h000A);

        // T5: reset in the middle of bit 3
        bus_write(2'd1, 16'h0001);
        b_r = sclk_rises;
        bus_write(2'd0, 16'h00C3);
        n = 0;
        while (sclk_rises - b_r < 4 && n < 200) begin
            @(negedge raw_clk);
            n++;
        end
        check("t5_reach_bit3", 16'(sclk_rises - b_r), 16'd4);
        reset = 1'b1;
        @(negedge raw_clk);
        check("t5_cs", {14'd0, spi_cs}, 16'h0003);
        check("t5_sclk", {15'd0, spi_clk}, 16'h0000);
        reset = 1'b0;
        read_check("t5_level", 2'd3, 16'h0000);
        read_check("t5_status", 2'd2, 16'h000A);
        read_check("t5_ctrl", 2'd1, 16'h0000);
        b_r = sclk_rises;
        repeat (40) @(negedge raw_clk);
        check("t5_no_sclk", 16'(sclk_rises - b_r), 16'd0);

        // T6: held enable pops once; cs_idx beyond NUM_CS drives no select
        bus_write(2'd1, 16'h0001);
        bus_write(2'd0, 16'h0021);
        bus_write(2'd0, 16'h0022);
        wait_idle("t6_idle");
        read_check("t6_level2", 2'd3, 16'h0200);
        @(negedge raw_clk);
        bus.enable = 1'b1;
        bus.write_enable = 1'b0;
        bus.address = 2'd0;
        repeat (5) @(negedge raw_clk);
        bus.enable = 1'b0;
        check("t6_hold_rx", bus.data_out, 16'h0021);
        read_check("t6_level1", 2'd3, 16'h0100);
        read_check("t6_rx2", 2'd0, 16'h0022);
        bus_write(2'd1, 16'h0301);
        b_r = sclk_rises; b_f = cs_falls;
        bus_write(2'd0, 16'h005A);
        wait_idle("t6_idle2");
        check("t6_no_cs", 16'(cs_falls - b_f), 16'd0);
        check("t6_rises", 16'(sclk_rises - b_r), 16'd8);
        read_check("t6_rx3", 2'd0, 16'h005A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
